// File: rtl/ho_pkg.sv
// ho_pkg: identities, state encoding and shared widths for the server/BS/MME handover blocks.
package ho_pkg;
  typedef logic [1:0] bs_id_t;
  localparam bs_id_t BS_NONE = 2'd3;
  localparam int DEF_DW = 4;
  typedef enum logic [1:0] {DETACHED = 2'd0, ATTACHED = 2'd1, HO_DRAIN = 2'd2} bs_state_e;
endpackage

// File: rtl/ho_fifo.sv
// ho_fifo: synchronous show-ahead FIFO; head is valid whenever empty is low.
module ho_fifo #(
  parameter int DW = 4,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp_q, rp_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign empty = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  // a full FIFO still accepts a push when the same cycle frees a slot
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem_q[rp_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (flush) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= do_push ? wp_q + 1'b1 : wp_q;
      rp_q <= do_pop ? rp_q + 1'b1 : rp_q;
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem_q[wp_q[AW-1:0]] <= din;
endmodule

// File: rtl/base_station_dl.sv
// base_station_dl: BS downlink buffer with MME-driven handover drain to a target BS.
// Optional drain watchdog enabled by defining BS_HO_TIMEOUT_EN.
module base_station_dl
  import ho_pkg::*;
#(
  parameter bs_id_t BS_ID = 2'd0,
  parameter int DW = DEF_DW,
  parameter int DEPTH = 8,
  parameter int HO_TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ue_attach,
  input  logic          ho_req,
  input  logic [1:0]    ho_target,
  output logic [1:0]    bs_sv_target,
  output logic          bs_sv_target_vld,
  input  logic [DW-1:0] sv_bs_data,
  input  logic          sv_bs_vld,
  output logic [DW-1:0] ue_data,
  output logic          ue_vld,
  input  logic          ue_rdy,
  output logic [DW-1:0] fwd_data,
  output logic          fwd_vld,
  input  logic          fwd_rdy,
  output logic          ho_fail,
  output logic [7:0]    drop_cnt,
  output logic [1:0]    bs_state
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HO_TIMEOUT < 1) $error("bad parameters");
  bs_state_e state_q, state_d;
  bs_id_t tgt_q, tgt_d;
  logic [7:0] drop_q;
  logic [DW-1:0] head;
  logic full, empty, push, pop, flush, timeout, drop;
  ho_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(reset), .flush(flush), .push(push), .pop(pop),
    .din(sv_bs_data), .head(head), .full(full), .empty(empty)
  );
  assign ue_vld = state_q == ATTACHED && !empty;
  assign fwd_vld = state_q == HO_DRAIN && !empty;
  assign ue_data = ue_vld ? head : '0;
  assign fwd_data = fwd_vld ? head : '0;
  assign pop = (ue_vld && ue_rdy) || (fwd_vld && fwd_rdy);
  assign push = sv_bs_vld && state_q != DETACHED;
  assign drop = push && full && !pop && !flush;
  assign bs_sv_target = state_q == DETACHED ? BS_NONE : state_q == ATTACHED ? BS_ID : tgt_q;
  assign bs_sv_target_vld = state_q != DETACHED;
  assign bs_state = state_q;
  assign drop_cnt = drop_q;
`ifdef BS_HO_TIMEOUT_EN
  localparam int TW = $clog2(HO_TIMEOUT + 1);
  logic [TW-1:0] to_q;
  logic ho_fail_q;
  assign timeout = state_q == HO_DRAIN && !pop && to_q == TW'(HO_TIMEOUT - 1);
  assign ho_fail = ho_fail_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      to_q <= '0;
      ho_fail_q <= 1'b0;
    end else begin
      to_q <= (state_q != HO_DRAIN || pop) ? '0 : to_q + 1'b1;
      ho_fail_q <= timeout;
    end
`else
  assign timeout = 1'b0;
  assign ho_fail = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    flush = 1'b0;
    case (state_q)
      DETACHED: state_d = ue_attach ? ATTACHED : DETACHED;
      // a valid handover command wins over a simultaneous detach
      ATTACHED:
        if (ho_req && ho_target != BS_ID && ho_target != BS_NONE) begin
          state_d = HO_DRAIN;
          tgt_d = ho_target;
        end else if (!ue_attach) begin
          state_d = DETACHED;
          flush = 1'b1;
        end
      HO_DRAIN:
        if (timeout) begin
          state_d = DETACHED;
          flush = 1'b1;
        end else if (empty && !sv_bs_vld) state_d = DETACHED;
      default: state_d = DETACHED;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= DETACHED;
      tgt_q <= BS_NONE;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      drop_q <= (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end
endmodule

// File: tb/tb_base_station_dl.sv
// tb_base_station_dl: directed plus randomized stimulus checked against a queue-based model of the BS downlink.
module tb_base_station_dl;
  import ho_pkg::*;
  localparam int DW = 4;
  localparam int DEPTH = 8;
  localparam int HO_TIMEOUT = 32;
  localparam bs_id_t BS_ID = 2'd0;
  logic clk = 1'b0, reset = 1'b0;
  logic ue_attach = 0, ho_req = 0, sv_bs_vld = 0, ue_rdy = 0, fwd_rdy = 0;
  logic [1:0] ho_target = 0;
  logic [DW-1:0] sv_bs_data = 0;
  logic [1:0] bs_sv_target, bs_state;
  logic bs_sv_target_vld, ue_vld, fwd_vld, ho_fail;
  logic [DW-1:0] ue_data, fwd_data;
  logic [7:0] drop_cnt;
  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] q[$];
  int m_st, m_drop;
  bs_id_t m_tgt;
  logic m_fail;
`ifdef BS_HO_TIMEOUT_EN
  int m_to;
`endif
  always #5 clk = ~clk;
  base_station_dl #(.BS_ID(BS_ID), .DW(DW), .DEPTH(DEPTH), .HO_TIMEOUT(HO_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ue_attach(ue_attach), .ho_req(ho_req), .ho_target(ho_target),
    .bs_sv_target(bs_sv_target), .bs_sv_target_vld(bs_sv_target_vld),
    .sv_bs_data(sv_bs_data), .sv_bs_vld(sv_bs_vld), .ue_data(ue_data), .ue_vld(ue_vld),
    .ue_rdy(ue_rdy), .fwd_data(fwd_data), .fwd_vld(fwd_vld), .fwd_rdy(fwd_rdy),
    .ho_fail(ho_fail), .drop_cnt(drop_cnt), .bs_state(bs_state)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_st = 0;
    m_drop = 0;
    m_tgt = BS_NONE;
    m_fail = 0;
`ifdef BS_HO_TIMEOUT_EN
    m_to = 0;
`endif
  endtask
  task automatic model_step();
    int st0 = m_st;
    bit popped, flush = 0;
    popped = q.size() > 0 && ((m_st == 1 && ue_rdy) || (m_st == 2 && fwd_rdy));
    m_fail = 0;
    if (st0 == 0) begin
      if (ue_attach) m_st = 1;
    end else if (st0 == 1) begin
      if (ho_req && ho_target != BS_ID && ho_target != 2'd3) begin
        m_st = 2;
        m_tgt = ho_target;
      end else if (!ue_attach) begin
        m_st = 0;
        flush = 1;
      end
    end else begin
`ifdef BS_HO_TIMEOUT_EN
      m_to = popped ? 0 : m_to + 1;
      if (m_to >= HO_TIMEOUT) begin
        m_st = 0;
        flush = 1;
        m_fail = 1;
      end
`endif
      if (!flush && q.size() == 0 && !sv_bs_vld) m_st = 0;
    end
`ifdef BS_HO_TIMEOUT_EN
    if (m_st != 2) m_to = 0;
`endif
    if (flush) q.delete();
    else if (st0 != 0) begin
      if (popped) void'(q.pop_front());
      if (sv_bs_vld) begin
        if (q.size() < DEPTH) q.push_back(sv_bs_data);
        else if (m_drop < 255) m_drop++;
      end
    end
  endtask
  task automatic check_outputs();
    bit uv = m_st == 1 && q.size() > 0;
    bit fv = m_st == 2 && q.size() > 0;
    chk("bs_state", bs_state, m_st);
    chk("sv_target", bs_sv_target, m_st == 0 ? 3 : m_st == 1 ? int'(BS_ID) : int'(m_tgt));
    chk("sv_target_vld", bs_sv_target_vld, m_st != 0);
    chk("ue_vld", ue_vld, uv);
    chk("ue_data", ue_data, uv ? int'(q[0]) : 0);
    chk("fwd_vld", fwd_vld, fv);
    chk("fwd_data", fwd_data, fv ? int'(q[0]) : 0);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("ho_fail", ho_fail, m_fail);
  endtask
  task automatic set_in(input logic a, input logic h, input logic [1:0] ht, input logic v,
                        input logic [DW-1:0] d, input logic ur, input logic fr);
    ue_attach = a; ho_req = h; ho_target = ht; sv_bs_vld = v; sv_bs_data = d; ue_rdy = ur; fwd_rdy = fr;
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic enter_drain(input logic [1:0] tgt, input int nwords);
    set_in(1, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < nwords; i++) begin set_in(1, 0, 0, 1, DW'(i + 3), 0, 0); tick(); end
    set_in(1, 1, tgt, 0, 0, 0, 0); tick();
  endtask
  initial begin
    logic [DW-1:0] abc [3] = '{4'hA, 4'hB, 4'hC};
    int pa, pv, pu, pf, ph;
    model_reset();
    #7 check_outputs();
    @(negedge clk);
    reset = 1'b1;
    set_in(1, 0, 0, 0, 0, 1, 1); tick();
    for (int i = 0; i < 3; i++) begin set_in(1, 0, 0, 1, abc[i], 1, 1); tick(); end
    set_in(1, 0, 0, 0, 0, 1, 1); repeat (3) tick();
    for (int i = 0; i < 10; i++) begin set_in(1, 0, 0, 1, DW'(i), 0, 1); tick(); end
    chk("drop_after_10", drop_cnt, 2);
    set_in(1, 0, 0, 0, 0, 1, 1); repeat (10) tick();
    for (int i = 0; i < 8; i++) begin set_in(1, 0, 0, 1, DW'(i + 5), 0, 1); tick(); end
    set_in(1, 0, 0, 1, 4'hF, 1, 1); tick();
    chk("full_push_pop_drop", drop_cnt, 2);
    set_in(1, 0, 2'd0, 0, 0, 0, 0); tick();
    set_in(1, 1, BS_ID, 0, 0, 0, 0); tick();
    set_in(1, 1, 2'd3, 0, 0, 0, 0); tick();
    chk("ignored_ho_target", bs_sv_target, BS_ID);
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 1); tick();
    for (int i = 0; i < 3; i++) begin set_in(1, 0, 0, 1, abc[i], 0, 1); tick(); end
    set_in(1, 1, 2'd2, 0, 0, 0, 1); tick();
    chk("ho_target_switch", bs_sv_target, 2);
    set_in(0, 0, 0, 1, 4'hD, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 1); repeat (6) tick();
    chk("drain_done_state", bs_state, 0);
    enter_drain(2'd1, 3);
    set_in(1, 0, 0, 0, 0, 0, 0); repeat (4) tick();
    do_reset();
    enter_drain(2'd2, 3);
    set_in(1, 0, 0, 0, 0, 0, 0); repeat (40) tick();
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      pa = seg == 0 ? 97 : seg == 1 ? 85 : seg == 2 ? 99 : 70;
      pv = seg == 0 ? 60 : seg == 1 ? 90 : seg == 2 ? 30 : 50;
      pu = seg == 0 ? 50 : seg == 1 ? 20 : seg == 2 ? 80 : 50;
      pf = seg == 0 ? 50 : seg == 1 ? 10 : seg == 2 ? 90 : 40;
      ph = seg == 2 ? 10 : 4;
      for (int c = 0; c < 400; c++) begin
        set_in($urandom_range(99) < pa, $urandom_range(99) < ph, 2'($urandom_range(3)),
               $urandom_range(99) < pv, DW'($urandom), $urandom_range(99) < pu, $urandom_range(99) < pf);
        tick();
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
